// File: rtl/sram_master.sv
// Burst master for a single-port synchronous SRAM: accepts read/write burst
// commands and streams beats through valid/ready handshakes.
module sram_master #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  input  logic          rsp_ready,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          mem_we,
  output logic          mem_rd
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RSP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] beats_left_q, beats_left_d;
  logic          done_q, done_d;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          state_d      = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          if (beats_left_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cur_addr_d   = cur_addr_q + AW'(1);
            beats_left_d = beats_left_q - AW'(1);
          end
        end
      end
      READ: state_d = RSP;
      RSP: begin
        // mem_dout holds its value until the next mem_rd, so stalling here keeps rsp_data stable
        if (rsp_ready) begin
          if (beats_left_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cur_addr_d   = cur_addr_q + AW'(1);
            beats_left_d = beats_left_q - AW'(1);
            state_d      = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      done_q       <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WRITE);
  assign mem_we    = wr_ready && wr_valid;
  assign mem_din   = wr_data;
  assign mem_rd    = (state_q == READ);
  assign mem_addr  = cur_addr_q;
  assign rsp_valid = (state_q == RSP);
  assign rsp_data  = mem_dout;
  assign rsp_last  = rsp_valid && (beats_left_q == '0);
  assign done      = done_q;

endmodule

// File: tb/tb_sram_master.sv
// Bench for sram_master: directed burst table, held-request and mid-burst
// reset sequences, then random bursts against a shadow memory.
module tb_sram_master;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned NA = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr, req_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rsp_valid, rsp_last, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we, mem_rd;

  always #5 clk = ~clk;

  sram_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_ready(rsp_ready), .done(done),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // SRAM with registered read port; contents survive reset
  logic [DW-1:0] sram [NA];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= sram[mem_addr];
  end

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] exp_mem [NA];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      check("mutex_we_rd", {31'b0, mem_we & mem_rd}, 0);
      if (req_ready) check("idle_quiet", {27'b0, mem_we, mem_rd, wr_ready, rsp_valid, rsp_last}, 0);
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_last"}, rsp_last, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic issue(input bit we, input bit [2:0] a, input bit [2:0] l, input bit hold);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
    #1;
    check("issue_req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // mode: 0 = wr_valid always 1, 1 = alternating gaps, 2 = random gaps
  task automatic write_body(input bit [2:0] a, input bit [2:0] l, input bit [63:0] data, input int mode);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    bit v;
    while (k <= int'(l) && cyc < 64) begin
      @(negedge clk);
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      stalls = v ? 0 : stalls + 1;
      wr_valid = v;
      wr_data = data[8*k +: 8];
      #1;
      if (cyc == 0) check("wr_done_low", done, 0);
      check("wr_ready", wr_ready, 1);
      check("wr_req_ready", req_ready, 0);
      check("wr_mem_we", mem_we, v);
      check("wr_mem_addr", mem_addr, (int'(a) + k) % 8);
      if (v) begin
        check("wr_mem_din", mem_din, data[8*k +: 8]);
        exp_mem[(int'(a) + k) % 8] = data[8*k +: 8];
        k++;
      end
      cyc++;
    end
    if (k <= int'(l)) check("wr_budget", k, l + 1);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check("wr_done", done, 1);
    check("wr_done_req_ready", req_ready, 1);
    check("wr_ready_idle", wr_ready, 0);
  endtask

  // mode: 0 = rsp_ready always 1, 1 = toggling 1/0, 2 = random stalls
  task automatic read_body(input bit [2:0] a, input bit [2:0] l, input bit [63:0] expd, input int mode);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    bit r;
    bit tog = 1'b1;
    while (k <= int'(l) && cyc < 64) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      if (k == 0) check("rd_done_low", done, 0);
      check("rd_mem_rd", mem_rd, 1);
      check("rd_mem_addr", mem_addr, (int'(a) + k) % 8);
      check("rd_rsp_valid_low", rsp_valid, 0);
      check("rd_req_ready", req_ready, 0);
      cyc++;
      r = 1'b0;
      while (!r && cyc < 64) begin
        @(negedge clk);
        case (mode)
          0: r = 1'b1;
          1: begin r = tog; tog = ~tog; end
          default: r = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
        stalls = r ? 0 : stalls + 1;
        rsp_ready = r;
        #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, expd[8*k +: 8]);
        check("rsp_last", rsp_last, (k == int'(l)));
        check("rsp_mem_rd", mem_rd, 0);
        check("rsp_req_ready", req_ready, 0);
        cyc++;
      end
      if (r) k++;
    end
    if (k <= int'(l)) check("rd_budget", k, l + 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("rd_done", done, 1);
    check("rd_done_req_ready", req_ready, 1);
    check("rd_rsp_valid_idle", rsp_valid, 0);
  endtask

  // For reads, data holds the expected response bytes (beat k in byte k)
  typedef struct {
    bit        we;
    bit [2:0]  addr;
    bit [2:0]  len;
    bit [63:0] data;
    int        mode;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit [63:0] d;
    bit [2:0]  a, l;
    vecs[0] = '{1'b1, 3'd5, 3'd0, 64'h0000_0000_0000_00A5, 0};
    vecs[1] = '{1'b0, 3'd5, 3'd0, 64'h0000_0000_0000_00A5, 0};
    vecs[2] = '{1'b1, 3'd6, 3'd3, 64'h0000_0000_4433_2211, 0};
    vecs[3] = '{1'b0, 3'd6, 3'd3, 64'h0000_0000_4433_2211, 0};
    vecs[4] = '{1'b1, 3'd2, 3'd7, 64'h1716_1514_1312_1110, 1};
    vecs[5] = '{1'b0, 3'd0, 3'd7, 64'h1514_1312_1110_1716, 1};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].len, 1'b0);
      if (vecs[i].we) write_body(vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].mode);
      else            read_body(vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].mode);
    end

    // Request held high through a burst is taken exactly at the done edge
    issue(1'b1, 3'd3, 3'd1, 1'b1);
    req_we = 1'b0; req_addr = 3'd3; req_len = 3'd1;
    write_body(3'd3, 3'd1, 64'h0000_0000_0000_BBAA, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    read_body(3'd3, 3'd1, 64'h0000_0000_0000_BBAA, 0);

    // Reset while a 4-beat read is stalled in its first response
    issue(1'b0, 3'd4, 3'd3, 1'b0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("mid_rst_read", mem_rd, 1);
    @(negedge clk);
    #1;
    check("mid_rst_rsp", rsp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    reset_checks("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_no_done", done, 0);
    check("mid_rst_idle", req_ready, 1);
    issue(1'b1, 3'd4, 3'd0, 1'b0);
    write_body(3'd4, 3'd0, 64'h5A, 0);
    issue(1'b0, 3'd4, 3'd0, 1'b0);
    read_body(3'd4, 3'd0, 64'h5A, 0);

    for (int i = 0; i < 40; i++) begin
      a = 3'($urandom_range(0, 7));
      l = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        issue(1'b1, a, l, 1'b0);
        write_body(a, l, d, int'($urandom_range(0, 2)));
      end else begin
        for (int k = 0; k < 8; k++) d[8*k +: 8] = exp_mem[(int'(a) + k) % 8];
        issue(1'b0, a, l, 1'b0);
        read_body(a, l, d, int'($urandom_range(0, 2)));
      end
    end

    @(negedge clk);
    for (int i = 0; i < int'(NA); i++) check("sram_content", sram[i], exp_mem[i]);

    mon_en = 1'b0;
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
